sd_stream_reader: RTL and testbench
===================================

# sd_stream_reader

Streams consecutive 512-byte SD blocks from the SD controller into an on-chip byte FIFO and presents them as 16-bit little-endian audio samples to the synth voice engine. Sits directly downstream of the SD controller: it drives the controller's `en`/`address`, consumes its response status and data bytes, and keeps the FIFO topped up so the sample consumer never stalls while data remains.

## Interface
- `FIFO_AW`, 10: FIFO address width. Depth is 2^FIFO_AW bytes and must be at least 1024.
- `ADDR_STEP`, 32'd1: address increment per block. Use 1 for block-addressed (SDHC) cards and 512 for byte-addressed cards.
- `TIMEOUT`, 20'hFFFFF: maximum clk cycles allowed waiting for a status or for the next data byte.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-low.
- `start` in 1: one-cycle pulse. Loads `base_addr`, flushes the FIFO and begins streaming. Only honoured in IDLE.
- `stop` in 1: one-cycle pulse. Requests a halt after the current block finishes.
- `base_addr` in 32: first block address.
- `sd_en` out 1: read request to the controller, one-cycle pulse.
- `sd_address` out 32: block address. Held stable from the `sd_en` pulse until the block ends.
- `sd_rdy` in 1: controller idle and able to accept a request.
- `sd_valid_status` in 1: one-cycle strobe marking `sd_resp_status` as valid.
- `sd_resp_status` in 7: R1 response. 0 means OK.
- `sd_data` in 8: data byte from the controller.
- `sd_data_valid` in 1: one-cycle strobe for `sd_data`.
- `sample` out 16: {second byte, first byte}.
- `sample_valid` out 1: `sample` holds a valid sample.
- `sample_ready` in 1: consumer accepts the sample.
- `busy` out 1: FSM is not in IDLE or ERR.
- `error` out 1: sticky. Cleared only by `start` or reset.
- `err_code` out 2: 1 = bad R1, 2 = timeout, 3 = FIFO overflow.
- `fifo_level` out FIFO_AW+1: bytes currently stored.

## Operation
- FSM states: IDLE, WAIT_SPACE, ISSUE, WAIT_RESP, RECV, ERR.
- IDLE, on `start`:
  - flush the FIFO (level 0, pointers 0);
  - load `sd_address` = `base_addr`;
  - clear `error` and `err_code`;
  - go to WAIT_SPACE.
- WAIT_SPACE:
  - if a stop is pending, go to IDLE;
  - otherwise, when free space ≥ 512 and `sd_rdy` = 1, go to ISSUE.
- ISSUE: assert `sd_en` for exactly one cycle, clear the watchdog, go to WAIT_RESP.
- WAIT_RESP, on `sd_valid_status`:
  - `sd_resp_status` == 0: go to RECV with the byte counter at 0;
  - otherwise: go to ERR with code 1.
- RECV:
  - each `sd_data_valid` pushes `sd_data` into the FIFO, increments the 9-bit byte counter and clears the watchdog;
  - on the 512th byte (counter wraps to 0): `sd_address` += `ADDR_STEP` (mod 2^32), go to WAIT_SPACE.
- Watchdog (WAIT_RESP and RECV): counts cycles and goes to ERR with code 2 when it reaches `TIMEOUT`.
- FIFO overflow: a push while the FIFO is full drops the byte and goes to ERR with code 3. This cannot occur in normal operation because of the space check.
- ERR:
  - `sd_en` stays 0;
  - FIFO contents remain readable;
  - leaves ERR only on `start`, which behaves exactly as a `start` from IDLE.
- `stop`:
  - sets a pending flag;
  - an in-flight block (WAIT_RESP or RECV) always completes, since an SD read cannot be abandoned;
  - the FIFO is not flushed;
  - the pending flag clears on entering IDLE or on `start`.
- `start` outside IDLE/ERR is ignored.
- Sample path:
  - `sample_valid` = 1 whenever `fifo_level` ≥ 2;
  - `sample` = {FIFO[rd+1], FIFO[rd]}, so the earlier byte is the LSB;
  - `sample_valid` && `sample_ready` pops 2 bytes.
- Level accounting: a push and a pop in the same cycle change the level by +1−2 = −1. Pointers wrap modulo 2^FIFO_AW.

## Timing
- Reset values: `sd_en`=0, `sd_address`=0, `sample`=0, `sample_valid`=0, `busy`=0, `error`=0, `err_code`=0, `fifo_level`=0, FSM=IDLE, stop flag=0.
- All outputs are registered.
- `start` at cycle N: `busy`=1 at N+1; `sd_en` pulse no earlier than N+2 (WAIT_SPACE, then ISSUE).
- `sd_en` is never asserted while `sd_rdy`=0 in the preceding cycle, and never twice per block.
- A byte pushed at cycle N counts in `fifo_level` at N+1. When this makes level ≥ 2, `sample_valid` is 1 at N+2 with `sample` valid.
- Pop accepted at cycle N: the next sample or `sample_valid`=0 appears at N+1. Back-to-back pops are allowed every cycle.
- Last byte of a block at cycle N: `sd_address` updated at N+1, next `sd_en` no earlier than N+2.
- Reset asserted mid-block: everything returns to reset values immediately. The controller is expected to be reset together with this block.

## Test plan
- Single block: `start`, `base_addr`=0x100; model returns R1=0 and bytes 0x00..0xFF twice; `sample_ready`=1 → `sd_address`=0x100 at the `sd_en` pulse, then samples 0x0100, 0x0302, …; exactly 256 samples; `sd_address`=0x101 afterwards.
- Backpressure: `sample_ready`=0 with `FIFO_AW`=10 → exactly two blocks are requested, `fifo_level`=1024 and no third `sd_en`. Raising `sample_ready` triggers a third request once level ≤ 512.
- Bad response: R1=0x04 → `error`=1, `err_code`=1, `busy`=0, no further `sd_en`. A following `start` clears `error`.
- Timeout: model stops after 100 data bytes, `TIMEOUT`=1000 → `err_code`=2 exactly 1000 cycles after the 100th byte; 50 samples remain readable.
- Stop mid-block: `stop` at byte 200 → the block completes (512 bytes pushed), then IDLE, with no further `sd_en`.
- Simultaneous push and pop at level 3 → level 2 the next cycle, and the sample order is preserved.

Source files
------------

// File: rtl/sd_stream_reader.sv
// sd_stream_reader
// Pulls consecutive 512-byte blocks from the SD controller into an on-chip
// byte FIFO and hands them out as 16-bit little-endian samples.
//
// Ports
//   clk, rst (async, active-low)
//   start/stop/base_addr       : control from the host
//   sd_en/sd_address           : read request towards the SD controller
//   sd_rdy/sd_valid_status/sd_resp_status/sd_data/sd_data_valid : controller replies
//   sample/sample_valid/sample_ready : sample stream towards the voice engine
//   busy/error/err_code/fifo_level   : status
module sd_stream_reader #(
    parameter int          FIFO_AW   = 10,
    parameter logic [31:0] ADDR_STEP = 32'd1,
    parameter logic [19:0] TIMEOUT   = 20'hFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      base_addr,
    output logic             sd_en,
    output logic [31:0]      sd_address,
    input  logic             sd_rdy,
    input  logic             sd_valid_status,
    input  logic [6:0]       sd_resp_status,
    input  logic [7:0]       sd_data,
    input  logic             sd_data_valid,
    output logic [15:0]      sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [FIFO_AW:0] fifo_level
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int LW    = FIFO_AW + 1;

    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [LW-1:0]      lvl_t;

    // A block is only requested when a whole block fits, so the FIFO cannot overflow
    // unless the controller misbehaves.
    localparam lvl_t SPACE_LIMIT = lvl_t'(DEPTH - 512);
    localparam lvl_t FULL_LEVEL  = lvl_t'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_SPACE, S_ISSUE, S_WAIT_RESP, S_RECV, S_ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [8:0]  cnt_reg, cnt_next;
    logic [19:0] wd_reg, wd_next;
    logic        stop_pend_reg, stop_pend_next;
    logic        error_reg, error_next;
    logic [1:0]  err_code_reg, err_code_next;
    logic        sd_en_reg, busy_reg;

    logic [7:0]  mem [DEPTH];
    ptr_t        wr_ptr_reg, wr_ptr_next;
    ptr_t        rd_ptr_reg, rd_ptr_next;
    lvl_t        level_reg, level_next, level_vis;
    logic [15:0] sample_reg;
    logic        sample_valid_reg;

    logic flush, push, pop, fifo_full;

    assign fifo_full = (level_reg == FULL_LEVEL);
    assign pop       = sample_valid_reg & sample_ready;

    // Control FSM: next state and datapath updates
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        cnt_next       = cnt_reg;
        wd_next        = wd_reg;
        stop_pend_next = stop_pend_reg | stop;
        error_next     = error_reg;
        err_code_next  = err_code_reg;
        flush          = 1'b0;
        push           = 1'b0;
        case (state_reg)
            S_IDLE, S_ERR: begin
                if (start) begin
                    flush          = 1'b1;
                    addr_next      = base_addr;
                    error_next     = 1'b0;
                    err_code_next  = 2'd0;
                    stop_pend_next = 1'b0;
                    state_next     = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (stop_pend_reg)
                    state_next = S_IDLE;
                else if (level_reg <= SPACE_LIMIT && sd_rdy)
                    state_next = S_ISSUE;
            end
            S_ISSUE: begin
                wd_next    = '0;
                state_next = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (sd_valid_status) begin
                    if (sd_resp_status == 7'd0) begin
                        cnt_next   = '0;
                        wd_next    = '0;
                        state_next = S_RECV;
                    end else begin
                        error_next    = 1'b1;
                        err_code_next = 2'd1;
                        state_next    = S_ERR;
                    end
                end else if (wd_reg == TIMEOUT - 20'd1) begin
                    error_next    = 1'b1;
                    err_code_next = 2'd2;
                    state_next    = S_ERR;
                end else begin
                    wd_next = wd_reg + 20'd1;
                end
            end
            S_RECV: begin
                if (sd_data_valid) begin
                    wd_next = '0;
                    if (fifo_full) begin
                        error_next    = 1'b1;
                        err_code_next = 2'd3;
                        state_next    = S_ERR;
                    end else begin
                        push     = 1'b1;
                        cnt_next = cnt_reg + 9'd1;
                        if (cnt_reg == 9'd511) begin
                            addr_next  = addr_reg + ADDR_STEP;
                            state_next = S_WAIT_SPACE;
                        end
                    end
                end else if (wd_reg == TIMEOUT - 20'd1) begin
                    error_next    = 1'b1;
                    err_code_next = 2'd2;
                    state_next    = S_ERR;
                end else begin
                    wd_next = wd_reg + 20'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (state_next == S_IDLE)
            stop_pend_next = 1'b0;
    end

    // FIFO pointer/level bookkeeping. level_vis excludes this cycle's push, so a
    // freshly written byte becomes poppable one cycle after it is counted in the level
    // (the memory write must land before the sample register reads it).
    always_comb begin
        wr_ptr_next = flush ? '0 : wr_ptr_reg + (push ? ptr_t'(1) : ptr_t'(0));
        rd_ptr_next = flush ? '0 : rd_ptr_reg + (pop ? ptr_t'(2) : ptr_t'(0));
        level_next  = flush ? '0 : level_reg + lvl_t'(push) - (pop ? lvl_t'(2) : lvl_t'(0));
        level_vis   = flush ? '0 : level_reg - (pop ? lvl_t'(2) : lvl_t'(0));
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= sd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= S_IDLE;
            addr_reg         <= '0;
            cnt_reg          <= '0;
            wd_reg           <= '0;
            stop_pend_reg    <= 1'b0;
            error_reg        <= 1'b0;
            err_code_reg     <= 2'd0;
            sd_en_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            addr_reg         <= addr_next;
            cnt_reg          <= cnt_next;
            wd_reg           <= wd_next;
            stop_pend_reg    <= stop_pend_next;
            error_reg        <= error_next;
            err_code_reg     <= err_code_next;
            sd_en_reg        <= (state_next == S_ISSUE);
            busy_reg         <= !(state_next inside {S_IDLE, S_ERR});
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            level_reg        <= level_next;
            sample_reg       <= {mem[rd_ptr_next + ptr_t'(1)], mem[rd_ptr_next]};
            sample_valid_reg <= (level_vis >= lvl_t'(2));
        end
    end

    assign sd_en        = sd_en_reg;
    assign sd_address   = addr_reg;
    assign sample       = sample_reg;
    assign sample_valid = sample_valid_reg;
    assign busy         = busy_reg;
    assign error        = error_reg;
    assign err_code     = err_code_reg;
    assign fifo_level   = level_reg;
endmodule

// File: tb/tb_sd_stream_reader.sv
// Testbench for sd_stream_reader: SD controller model, byte-queue scoreboard
// for the sample stream, and one task per scenario.
module tb_sd_stream_reader;
    localparam int AW = 10;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
    logic [31:0] base_addr = '0;
    logic        sd_en;
    logic [31:0] sd_address;
    logic        sd_rdy = 1'b1, sd_valid_status = 1'b0;
    logic [6:0]  sd_resp_status = '0;
    logic [7:0]  sd_data = '0;
    logic        sd_data_valid = 1'b0;
    logic [15:0] sample;
    logic        sample_valid, sample_ready = 1'b0, busy, error;
    logic [1:0]  err_code;
    logic [AW:0] fifo_level;

    int checks = 0, failures = 0;

    // controller model configuration
    logic [6:0] cfg_status = '0;
    int         cfg_nbytes = 512;
    int         cfg_gap_max = 2;
    bit         cfg_random = 1'b0;
    logic [31:0] en_addrs[$];

    // scoreboard state
    logic [7:0]  exp_q[$];
    logic [15:0] popped_q[$];
    int model_level = 0;
    bit prev_push = 1'b0, prev_rdy = 1'b1;
    int pop_count = 0, block_bytes = 0, last_byte_edge = 0, cyc = 0;

    sd_stream_reader #(.FIFO_AW(AW), .ADDR_STEP(32'd1), .TIMEOUT(20'd1000)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .base_addr(base_addr),
        .sd_en(sd_en), .sd_address(sd_address), .sd_rdy(sd_rdy),
        .sd_valid_status(sd_valid_status), .sd_resp_status(sd_resp_status),
        .sd_data(sd_data), .sd_data_valid(sd_data_valid),
        .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .busy(busy), .error(error), .err_code(err_code), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // SD controller model: answers each sd_en with a status and (if OK) a block of bytes
    always begin
        @(posedge clk); #1;
        if (sd_en === 1'b1 && rst) begin
            en_addrs.push_back(sd_address);
            sd_rdy = 1'b0;
            repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            sd_resp_status = cfg_status;
            sd_valid_status = 1'b1;
            @(posedge clk); #1;
            sd_valid_status = 1'b0;
            if (cfg_status == 7'd0) begin
                for (int i = 0; i < cfg_nbytes; i++) begin
                    repeat ($urandom_range(0, cfg_gap_max)) begin @(posedge clk); #1; end
                    sd_data = cfg_random ? 8'($urandom) : 8'(i);
                    sd_data_valid = 1'b1;
                    @(posedge clk); #1;
                    sd_data_valid = 1'b0;
                end
            end
            sd_rdy = 1'b1;
        end
    end

    // Scoreboard: every byte the controller delivers must come out, in order,
    // as {later byte, earlier byte}; level follows pushes (+1) and pops (-2).
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            model_level = 0;
            prev_push = 1'b0;
            prev_rdy = sd_rdy;
        end else begin
            checks++;
            if (fifo_level !== (AW+1)'(model_level)) begin
                failures++;
                $display("FAIL level: got %0d expected %0d at cycle %0d", fifo_level, model_level, cyc);
            end
            checks++;
            if (sample_valid !== ((model_level - int'(prev_push)) >= 2)) begin
                failures++;
                $display("FAIL sample_valid: got %0b with level %0d at cycle %0d", sample_valid, model_level, cyc);
            end
            if (sd_en === 1'b1) begin
                checks++;
                if (!prev_rdy || fifo_level > 512) begin
                    failures++;
                    $display("FAIL sd_en_guard: prev sd_rdy %0b level %0d at cycle %0d", prev_rdy, fifo_level, cyc);
                end
            end
            if (sample_valid && sample_ready) begin
                checks++;
                if (exp_q.size() < 2) begin
                    failures++;
                    $display("FAIL pop_underflow: popped %h with %0d bytes expected", sample, exp_q.size());
                end else begin
                    if (sample !== {exp_q[1], exp_q[0]}) begin
                        failures++;
                        $display("FAIL sample_data: got %h expected %h", sample, {exp_q[1], exp_q[0]});
                    end
                    void'(exp_q.pop_front());
                    void'(exp_q.pop_front());
                end
                popped_q.push_back(sample);
                pop_count++;
                model_level -= 2;
            end
            if (sd_data_valid) begin
                exp_q.push_back(sd_data);
                model_level += 1;
                block_bytes++;
                last_byte_edge = cyc + 1;
            end
            prev_push = sd_data_valid;
            if (start && !busy) begin
                exp_q.delete();
                model_level = 0;
                prev_push = 1'b0;
                block_bytes = 0;
            end
            prev_rdy = sd_rdy;
        end
    end

    task automatic pulse_start(input logic [31:0] addr);
        @(posedge clk); #1;
        base_addr = addr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        sample_ready = 1'b1;
        for (int i = 0; i < 2000 && fifo_level != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (sd_en !== 1'b0 || sd_address !== 32'd0 || sample !== 16'd0 || sample_valid !== 1'b0 ||
            busy !== 1'b0 || error !== 1'b0 || err_code !== 2'd0 || fifo_level !== '0) begin
            failures++;
            $display("FAIL reset_values: en=%0b addr=%h sample=%h sv=%0b busy=%0b err=%0b code=%0d level=%0d",
                     sd_en, sd_address, sample, sample_valid, busy, error, err_code, fifo_level);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sd_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%0b sd_en=%0b", busy, sd_en);
        end
        $display("reset: done");
    endtask

    task automatic test_single_block();
        logic [15:0] exp_s;
        sample_ready = 1'b1; cfg_status = '0; cfg_nbytes = 512; cfg_random = 1'b0;
        en_addrs.delete(); popped_q.delete();
        pulse_start(32'h100);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start: got %0b expected 1", busy);
        end
        for (int i = 0; i < 100 && en_addrs.size() == 0; i++) @(negedge clk);
        pulse_stop();
        wait_idle(5000);
        drain();
        checks++;
        if (en_addrs.size() != 1 || en_addrs[0] !== 32'h100) begin
            failures++;
            $display("FAIL single_request: %0d requests, first addr %h expected 1 at 00000100",
                     en_addrs.size(), en_addrs.size() > 0 ? en_addrs[0] : 32'hx);
        end
        checks++;
        if (popped_q.size() != 256) begin
            failures++;
            $display("FAIL sample_count: got %0d expected 256", popped_q.size());
        end
        for (int k = 0; k < 256 && k < popped_q.size(); k++) begin
            exp_s = {8'(2*k + 1), 8'(2*k)};
            checks++;
            if (popped_q[k] !== exp_s) begin
                failures++;
                $display("FAIL sample_%0d: got %h expected %h", k, popped_q[k], exp_s);
            end
        end
        checks++;
        if (sd_address !== 32'h101) begin
            failures++;
            $display("FAIL next_address: got %h expected 00000101", sd_address);
        end
        $display("single_block: %0d samples, address now %h", popped_q.size(), sd_address);
    endtask

    task automatic test_backpressure();
        logic [31:0] base;
        base = $urandom;
        sample_ready = 1'b0; cfg_random = 1'b1;
        en_addrs.delete();
        pulse_start(base);
        for (int i = 0; i < 6000 && fifo_level != 1024; i++) @(negedge clk);
        repeat (100) @(negedge clk);
        checks++;
        if (en_addrs.size() != 2 || fifo_level !== 11'd1024) begin
            failures++;
            $display("FAIL two_blocks_full: %0d requests, level %0d expected 2 and 1024", en_addrs.size(), fifo_level);
        end
        @(posedge clk); #1;
        sample_ready = 1'b1;
        for (int i = 0; i < 2000 && en_addrs.size() < 3; i++) @(negedge clk);
        checks++;
        if (en_addrs.size() != 3 || fifo_level > 512) begin
            failures++;
            $display("FAIL third_request: %0d requests, level %0d expected 3 and <=512", en_addrs.size(), fifo_level);
        end
        pulse_stop();
        wait_idle(5000);
        drain();
        for (int k = 0; k < en_addrs.size(); k++) begin
            checks++;
            if (en_addrs[k] !== base + 32'(k)) begin
                failures++;
                $display("FAIL block_addr_%0d: got %h expected %h", k, en_addrs[k], base + 32'(k));
            end
        end
        $display("backpressure: %0d requests from %h", en_addrs.size(), base);
    endtask

    task automatic test_bad_response();
        sample_ready = 1'b1; cfg_status = 7'h04;
        en_addrs.delete();
        pulse_start($urandom);
        for (int i = 0; i < 200 && !error; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        checks++;
        if (error !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0 || en_addrs.size() != 1) begin
            failures++;
            $display("FAIL bad_r1: error=%0b code=%0d busy=%0b requests=%0d expected 1/1/0/1",
                     error, err_code, busy, en_addrs.size());
        end
        cfg_status = '0;
        pulse_start($urandom);
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clears: error=%0b code=%0d busy=%0b expected 0/0/1", error, err_code, busy);
        end
        for (int i = 0; i < 100 && en_addrs.size() < 2; i++) @(negedge clk);
        pulse_stop();
        wait_idle(5000);
        drain();
        $display("bad_response: error path and restart done");
    endtask

    task automatic test_timeout();
        int pops0;
        sample_ready = 1'b0; cfg_nbytes = 100; cfg_random = 1'b1;
        pulse_start($urandom);
        for (int i = 0; i < 4000 && !error; i++) @(negedge clk);
        checks++;
        if (err_code !== 2'd2 || (cyc - last_byte_edge) != 1000) begin
            failures++;
            $display("FAIL timeout: code=%0d after %0d cycles expected 2 after 1000", err_code, cyc - last_byte_edge);
        end
        checks++;
        if (fifo_level !== 11'd100 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_state: level=%0d busy=%0b expected 100/0", fifo_level, busy);
        end
        pops0 = pop_count;
        drain();
        checks++;
        if (pop_count - pops0 != 50 || sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_readout: %0d samples expected 50", pop_count - pops0);
        end
        cfg_nbytes = 512;
        $display("timeout: err_code=%0d, %0d samples read", err_code, pop_count - pops0);
    endtask

    task automatic test_stop_mid_block();
        sample_ready = 1'b1; cfg_random = 1'b1;
        en_addrs.delete();
        pulse_start($urandom);
        for (int i = 0; i < 3000 && block_bytes < 200; i++) @(negedge clk);
        pulse_stop();
        wait_idle(5000);
        repeat (50) @(negedge clk);
        checks++;
        if (block_bytes != 512 || en_addrs.size() != 1 || busy !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL stop_mid_block: bytes=%0d requests=%0d busy=%0b expected 512/1/0",
                     block_bytes, en_addrs.size(), busy);
        end
        drain();
        $display("stop_mid_block: %0d bytes, %0d request", block_bytes, en_addrs.size());
    endtask

    task automatic test_back_to_back();
        bit armed = 1'b0, found = 1'b0;
        cfg_random = 1'b1;
        pulse_start($urandom);
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge clk); #1;
            sample_ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (armed) begin
                checks++;
                if (fifo_level !== 11'd2) begin
                    failures++;
                    $display("FAIL push_pop_level: got %0d expected 2", fifo_level);
                end
                found = 1'b1;
            end
            armed = (sd_data_valid && sample_valid && sample_ready && fifo_level == 11'd3);
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL push_pop_seen: no simultaneous push and pop at level 3");
        end
        @(posedge clk); #1;
        sample_ready = 1'b1;
        pulse_stop();
        wait_idle(5000);
        drain();
        $display("back_to_back: push+pop at level 3 seen=%0b", found);
    endtask

    task automatic test_async_reset();
        sample_ready = 1'b0; cfg_random = 1'b1;
        en_addrs.delete();
        pulse_start($urandom | 32'h1);
        for (int i = 0; i < 3000 && fifo_level < 10; i++) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_level !== '0 || sd_address !== 32'd0 || sd_en !== 1'b0 ||
            sample_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%0b level=%0d addr=%h", busy, fifo_level, sd_address);
        end
        for (int i = 0; i < 3000 && !sd_rdy; i++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (en_addrs.size() != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_idle: requests=%0d busy=%0b expected 1/0", en_addrs.size(), busy);
        end
        $display("async_reset: done");
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_bad_response();
        test_timeout();
        test_stop_mid_block();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
